// File: rtl/smc_feeder.sv
// -----------------------------------------------------------------------------
// smc_feeder
//
// Sequential front-end for the SMC (Supper MOSFET Calculator) combinational
// block. Six MOSFET parameter triples (W, V_GS, V_DS) arrive serially, one per
// cycle, and are presented in parallel on registered SMC operand ports. After
// SETTLE_CYC cycles the SMC result (smc_out_n) is captured and returned on
// out_n with a single-cycle out_valid strobe.
//
// Handshake: in_valid is a plain valid with no ready/backpressure. A beat is
// consumed on every rising edge where in_valid is 1 and the FSM is in IDLE or
// LOAD. Beats must be contiguous: a low in_valid during LOAD aborts the
// transaction. While busy is high past the load phase (SETTLE/OUT), in_valid
// is ignored and changes no register.
//
// Parameters:
//   SETTLE_CYC   cycles from the final operand update to the smc_out_n
//                capture (1..7)
//
// Build option:
//   SMC_FEED_CLR_EN  when defined, all SMC operand ports and mode are cleared
//                    on the edge leaving OUT and on a LOAD abort, so SMC sees
//                    all-zero operands while idle. When undefined, the ports
//                    hold their last written values.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid                    beat valid
//   in_w, in_vgs, in_vds        operands of the current transistor
//   in_mode                     SMC mode, sampled on beat 0 only
//   smc_out_n                   result returned from SMC
//   W_k, V_GS_k, V_DS_k (k=0..5) registered SMC operand ports
//   mode                        registered SMC mode
//   busy                        transaction in progress
//   out_valid                   single-cycle result strobe
//   out_n                       captured result, zero outside out_valid
// -----------------------------------------------------------------------------
module smc_feeder #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_w,
    input  logic [2:0] in_vgs,
    input  logic [2:0] in_vds,
    input  logic [1:0] in_mode,
    input  logic [7:0] smc_out_n,
    output logic [2:0] W_0,
    output logic [2:0] W_1,
    output logic [2:0] W_2,
    output logic [2:0] W_3,
    output logic [2:0] W_4,
    output logic [2:0] W_5,
    output logic [2:0] V_GS_0,
    output logic [2:0] V_GS_1,
    output logic [2:0] V_GS_2,
    output logic [2:0] V_GS_3,
    output logic [2:0] V_GS_4,
    output logic [2:0] V_GS_5,
    output logic [2:0] V_DS_0,
    output logic [2:0] V_DS_1,
    output logic [2:0] V_DS_2,
    output logic [2:0] V_DS_3,
    output logic [2:0] V_DS_4,
    output logic [2:0] V_DS_5,
    output logic [1:0] mode,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam logic [2:0] LAST_BEAT   = 3'd5;
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] beat_cnt;
    logic [2:0] settle_cnt;
    logic [2:0] w_q   [6];
    logic [2:0] vgs_q [6];
    logic [2:0] vds_q [6];
    logic [1:0] mode_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (!in_valid)                  state_nxt = IDLE;
                else if (beat_cnt == LAST_BEAT) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) state_nxt = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, counters and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) begin
                w_q[k]   <= '0;
                vgs_q[k] <= '0;
                vds_q[k] <= '0;
            end
            mode_q     <= '0;
            beat_cnt   <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_n      <= '0;
        end else begin
            // out_n is only meaningful alongside the strobe
            out_valid <= 1'b0;
            out_n     <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        w_q[0]   <= in_w;
                        vgs_q[0] <= in_vgs;
                        vds_q[0] <= in_vds;
                        mode_q   <= in_mode;
                        beat_cnt <= 3'd1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        for (int k = 1; k < 6; k++) begin
                            if (beat_cnt == 3'(k)) begin
                                w_q[k]   <= in_w;
                                vgs_q[k] <= in_vgs;
                                vds_q[k] <= in_vds;
                            end
                        end
                        // Saturates at the last beat; SETTLE takes over there
                        if (beat_cnt != LAST_BEAT) beat_cnt <= beat_cnt + 3'd1;
                        settle_cnt <= '0;
                    end else begin
                        beat_cnt <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 3'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        out_n     <= smc_out_n;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    beat_cnt <= '0;
                end
                default: ;
            endcase
`ifdef SMC_FEED_CLR_EN
            // Leaving a transaction (completed or aborted) zeroes the SMC side
            if ((state == OUT) || ((state == LOAD) && !in_valid)) begin
                for (int k = 0; k < 6; k++) begin
                    w_q[k]   <= '0;
                    vgs_q[k] <= '0;
                    vds_q[k] <= '0;
                end
                mode_q <= '0;
            end
`else
`endif
        end
    end

    assign W_0    = w_q[0];
    assign W_1    = w_q[1];
    assign W_2    = w_q[2];
    assign W_3    = w_q[3];
    assign W_4    = w_q[4];
    assign W_5    = w_q[5];
    assign V_GS_0 = vgs_q[0];
    assign V_GS_1 = vgs_q[1];
    assign V_GS_2 = vgs_q[2];
    assign V_GS_3 = vgs_q[3];
    assign V_GS_4 = vgs_q[4];
    assign V_GS_5 = vgs_q[5];
    assign V_DS_0 = vds_q[0];
    assign V_DS_1 = vds_q[1];
    assign V_DS_2 = vds_q[2];
    assign V_DS_3 = vds_q[3];
    assign V_DS_4 = vds_q[4];
    assign V_DS_5 = vds_q[5];
    assign mode   = mode_q;

endmodule

// File: tb/tb_smc_feeder.sv
// -----------------------------------------------------------------------------
// tb_smc_feeder
//
// Two feeders run in lockstep on shared stimulus: dut1 with SETTLE_CYC=1 and
// dut4 with SETTLE_CYC=4 (dut4 has its own in_valid so it can be poked while
// settling). Cycle index c=0 is the beat-0 cycle T0 of each transaction.
// -----------------------------------------------------------------------------
module tb_smc_feeder;

    localparam int CYC = 14;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv1, iv4;
    logic [2:0] in_w, in_vgs, in_vds;
    logic [1:0] in_mode;
    logic [7:0] smc1, smc4;

    logic [2:0] o1_w [6], o1_vgs [6], o1_vds [6];
    logic [2:0] o4_w [6], o4_vgs [6], o4_vds [6];
    logic [1:0] o1_mode, o4_mode;
    logic       o1_busy, o1_ov, o4_busy, o4_ov;
    logic [7:0] o1_on, o4_on;

    smc_feeder #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1),
        .in_w(in_w), .in_vgs(in_vgs), .in_vds(in_vds), .in_mode(in_mode),
        .smc_out_n(smc1),
        .W_0(o1_w[0]), .W_1(o1_w[1]), .W_2(o1_w[2]),
        .W_3(o1_w[3]), .W_4(o1_w[4]), .W_5(o1_w[5]),
        .V_GS_0(o1_vgs[0]), .V_GS_1(o1_vgs[1]), .V_GS_2(o1_vgs[2]),
        .V_GS_3(o1_vgs[3]), .V_GS_4(o1_vgs[4]), .V_GS_5(o1_vgs[5]),
        .V_DS_0(o1_vds[0]), .V_DS_1(o1_vds[1]), .V_DS_2(o1_vds[2]),
        .V_DS_3(o1_vds[3]), .V_DS_4(o1_vds[4]), .V_DS_5(o1_vds[5]),
        .mode(o1_mode), .busy(o1_busy), .out_valid(o1_ov), .out_n(o1_on)
    );

    smc_feeder #(.SETTLE_CYC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4),
        .in_w(in_w), .in_vgs(in_vgs), .in_vds(in_vds), .in_mode(in_mode),
        .smc_out_n(smc4),
        .W_0(o4_w[0]), .W_1(o4_w[1]), .W_2(o4_w[2]),
        .W_3(o4_w[3]), .W_4(o4_w[4]), .W_5(o4_w[5]),
        .V_GS_0(o4_vgs[0]), .V_GS_1(o4_vgs[1]), .V_GS_2(o4_vgs[2]),
        .V_GS_3(o4_vgs[3]), .V_GS_4(o4_vgs[4]), .V_GS_5(o4_vgs[5]),
        .V_DS_0(o4_vds[0]), .V_DS_1(o4_vds[1]), .V_DS_2(o4_vds[2]),
        .V_DS_3(o4_vds[3]), .V_DS_4(o4_vds[4]), .V_DS_5(o4_vds[5]),
        .mode(o4_mode), .busy(o4_busy), .out_valid(o4_ov), .out_n(o4_on)
    );

    // ---------------- stimulus and observation state ----------------
    int         checks;
    int         failures;
    int         n_beats;
    int         rst_at;
    int         pulse4_at;
    logic [2:0] stim_w [6], stim_vgs [6], stim_vds [6];
    logic [1:0] stim_mode;
    logic [7:0] smc_sched [2][CYC];
    logic [2:0] prev_w [6], prev_vgs [6], prev_vds [6];
    logic [1:0] prev_mode;

    logic [2:0] obs_w [2][CYC][6], obs_vgs [2][CYC][6], obs_vds [2][CYC][6];
    logic [1:0] obs_mode [2][CYC];
    logic       obs_ov [2][CYC], obs_busy [2][CYC];
    logic [7:0] obs_on [2][CYC];

    // ---------------- reference model ----------------
    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Operand port value seen in cycle c of the current transaction
    function automatic logic [2:0] exp_op(input int d, input int c, input int k,
                                          input logic [2:0] newv, input logic [2:0] oldv);
`ifdef SMC_FEED_CLR_EN
        int clr_t;
        clr_t = (n_beats == 6) ? 7 + settle_of(d) : n_beats + 1;
        if (n_beats > 0 && c >= clr_t) return 3'd0;
`endif
        if (k < n_beats && c >= k + 1) return newv;
        return oldv;
    endfunction

    function automatic logic exp_ov(input int d, input int c);
        return (n_beats == 6) && (c == 6 + settle_of(d));
    endfunction

    function automatic logic [7:0] exp_on(input int d, input int c);
        return exp_ov(d, c) ? smc_sched[d][5 + settle_of(d)] : 8'h00;
    endfunction

    // busy in the abort cycle itself is not pinned down; skip it
    function automatic logic busy_known(input int c);
        return (n_beats == 6) || (c != n_beats);
    endfunction

    function automatic logic exp_busy(input int d, input int c);
        if (n_beats == 6) return (c >= 1) && (c <= 6 + settle_of(d));
        return (c >= 1) && (c < n_beats);
    endfunction

    function automatic logic ports_or(input int d, input int c);
        logic r;
        r = |obs_mode[d][c];
        for (int k = 0; k < 6; k++)
            r = r | (|obs_w[d][c][k]) | (|obs_vgs[d][c][k]) | (|obs_vds[d][c][k]);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic sample(input int c);
        for (int k = 0; k < 6; k++) begin
            obs_w[0][c][k]   = o1_w[k];
            obs_vgs[0][c][k] = o1_vgs[k];
            obs_vds[0][c][k] = o1_vds[k];
            obs_w[1][c][k]   = o4_w[k];
            obs_vgs[1][c][k] = o4_vgs[k];
            obs_vds[1][c][k] = o4_vds[k];
        end
        obs_mode[0][c] = o1_mode;  obs_mode[1][c] = o4_mode;
        obs_ov[0][c]   = o1_ov;    obs_ov[1][c]   = o4_ov;
        obs_on[0][c]   = o1_on;    obs_on[1][c]   = o4_on;
        obs_busy[0][c] = o1_busy;  obs_busy[1][c] = o4_busy;
    endtask

    task automatic randomize_stim();
        for (int k = 0; k < 6; k++) begin
            stim_w[k]   = 3'($urandom_range(0, 7));
            stim_vgs[k] = 3'($urandom_range(0, 7));
            stim_vds[k] = 3'($urandom_range(0, 7));
        end
        stim_mode = 2'($urandom_range(0, 3));
        for (int c = 0; c < CYC; c++) begin
            smc_sched[0][c] = 8'($urandom_range(1, 255));
            smc_sched[1][c] = 8'($urandom_range(1, 255));
        end
    endtask

    task automatic commit_prev();
        for (int k = 0; k < 6; k++) begin
`ifdef SMC_FEED_CLR_EN
            prev_w[k] = 3'd0; prev_vgs[k] = 3'd0; prev_vds[k] = 3'd0;
`else
            if (k < n_beats) begin
                prev_w[k] = stim_w[k]; prev_vgs[k] = stim_vgs[k]; prev_vds[k] = stim_vds[k];
            end
`endif
        end
`ifdef SMC_FEED_CLR_EN
        prev_mode = 2'd0;
`else
        if (n_beats > 0) prev_mode = stim_mode;
`endif
    endtask

    // Drives one transaction of n_beats contiguous beats, then idles
    task automatic run_txn();
        for (int c = 0; c < CYC; c++) begin
            @(posedge clk); #1;
            rst_n = (c == rst_at) ? 1'b0 : 1'b1;
            if (c < n_beats) begin
                iv1 = 1'b1; iv4 = 1'b1;
                in_w = stim_w[c]; in_vgs = stim_vgs[c]; in_vds = stim_vds[c];
                in_mode = (c == 0) ? stim_mode : 2'($urandom_range(0, 3));
            end else begin
                iv1 = 1'b0;
                iv4 = (c == pulse4_at);
                in_w = 3'($urandom_range(0, 7)); in_vgs = 3'($urandom_range(0, 7));
                in_vds = 3'($urandom_range(0, 7)); in_mode = 2'($urandom_range(0, 3));
            end
            smc1 = smc_sched[0][c];
            smc4 = smc_sched[1][c];
            #2;
            sample(c);
        end
        iv1 = 1'b0; iv4 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            rst_n   = (c < 2) ? 1'b0 : 1'b1;
            iv1     = (c < 2); iv4 = (c < 2);
            in_w    = 3'd7; in_vgs = 3'd7; in_vds = 3'd7; in_mode = 2'd3;
            #2;
            sample(c);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (ports_or(d, c) !== 1'b0) begin
                    failures++; $display("FAIL reset_ports d=%0d c=%0d got=nonzero exp=0", d, c);
                end
                checks++;
                if ({obs_busy[d][c], obs_ov[d][c], obs_on[d][c]} !== 10'd0) begin
                    failures++;
                    $display("FAIL reset_ctl d=%0d c=%0d busy=%0b ov=%0b on=%0h exp=0",
                             d, c, obs_busy[d][c], obs_ov[d][c], obs_on[d][c]);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            prev_w[k] = 3'd0; prev_vgs[k] = 3'd0; prev_vds[k] = 3'd0;
        end
        prev_mode = 2'd0;
    endtask

    task automatic test_full();
        n_beats = 6;
        for (int k = 0; k < 6; k++) begin
            stim_w[k] = 3'(k + 1); stim_vgs[k] = 3'(k); stim_vds[k] = 3'(7 - k);
        end
        stim_mode = 2'b11;
        for (int c = 0; c < CYC; c++) begin
            smc_sched[0][c] = 8'h5C; smc_sched[1][c] = 8'h5C;
        end
        run_txn();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs_w[0][6][k] !== 3'(k + 1)) begin
                failures++; $display("FAIL full_w k=%0d got=%0d exp=%0d", k, obs_w[0][6][k], k + 1);
            end
        end
        checks++;
        if (obs_vds[0][6][5] !== 3'd2) begin
            failures++; $display("FAIL full_vds5 got=%0d exp=2", obs_vds[0][6][5]);
        end
        checks++;
        if (obs_mode[0][6] !== 2'd3) begin
            failures++; $display("FAIL full_mode got=%0d exp=3", obs_mode[0][6]);
        end
        for (int c = 0; c < CYC; c++) begin
            checks++;
            if (obs_ov[0][c] !== (c == 7) || obs_on[0][c] !== ((c == 7) ? 8'h5C : 8'h00)) begin
                failures++;
                $display("FAIL full_out c=%0d ov=%0b on=%0h exp_ov=%0b", c, obs_ov[0][c], obs_on[0][c], c == 7);
            end
            checks++;
            if (obs_busy[0][c] !== (c >= 1 && c <= 7)) begin
                failures++; $display("FAIL full_busy c=%0d got=%0b", c, obs_busy[0][c]);
            end
            checks++;
            if (obs_ov[1][c] !== (c == 10)) begin
                failures++; $display("FAIL full_ov4 c=%0d got=%0b exp=%0b", c, obs_ov[1][c], c == 10);
            end
        end
        // Idle-side SMC view after completion
        for (int k = 0; k < 6; k++) begin
            checks++;
`ifdef SMC_FEED_CLR_EN
            if (obs_w[0][8][k] !== 3'd0 || obs_mode[0][8] !== 2'd0) begin
                failures++; $display("FAIL full_clear k=%0d w=%0d mode=%0d exp=0", k, obs_w[0][8][k], obs_mode[0][8]);
            end
`else
            if (obs_w[0][8][k] !== 3'(k + 1) || obs_mode[0][8] !== 2'd3) begin
                failures++; $display("FAIL full_hold k=%0d w=%0d mode=%0d", k, obs_w[0][8][k], obs_mode[0][8]);
            end
`endif
        end
        commit_prev();
    endtask

    task automatic test_abort();
        n_beats = 3;
        randomize_stim();
        run_txn();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CYC; c++) begin
                checks++;
                if (obs_ov[d][c] !== 1'b0 || obs_on[d][c] !== 8'h00) begin
                    failures++; $display("FAIL abort_out d=%0d c=%0d ov=%0b on=%0h", d, c, obs_ov[d][c], obs_on[d][c]);
                end
                if (busy_known(c)) begin
                    checks++;
                    if (obs_busy[d][c] !== exp_busy(d, c)) begin
                        failures++; $display("FAIL abort_busy d=%0d c=%0d got=%0b", d, c, obs_busy[d][c]);
                    end
                end
            end
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (obs_w[d][3][k] !== ((k < 3) ? stim_w[k] : prev_w[k])) begin
                    failures++; $display("FAIL abort_partial d=%0d k=%0d got=%0d", d, k, obs_w[d][3][k]);
                end
                checks++;
                if (obs_vds[d][6][k] !== exp_op(d, 6, k, stim_vds[k], prev_vds[k])) begin
                    failures++; $display("FAIL abort_after d=%0d k=%0d got=%0d", d, k, obs_vds[d][6][k]);
                end
            end
        end
        commit_prev();
        // A following full transaction carries its own values
        n_beats = 6;
        randomize_stim();
        run_txn();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs_w[0][6][k] !== stim_w[k] || obs_vgs[0][6][k] !== stim_vgs[k] || obs_vds[0][6][k] !== stim_vds[k]) begin
                failures++; $display("FAIL abort_next_ops k=%0d w=%0d exp=%0d", k, obs_w[0][6][k], stim_w[k]);
            end
        end
        checks++;
        if (obs_ov[0][7] !== 1'b1 || obs_on[0][7] !== smc_sched[0][6]) begin
            failures++; $display("FAIL abort_next_out ov=%0b on=%0h exp=%0h", obs_ov[0][7], obs_on[0][7], smc_sched[0][6]);
        end
        commit_prev();
    endtask

    task automatic test_settle_window();
        n_beats = 6;
        randomize_stim();
        for (int c = 0; c < CYC; c++) smc_sched[1][c] = (c < 9) ? 8'h11 : 8'h22;
        pulse4_at = 8;
        run_txn();
        pulse4_at = -1;
        for (int c = 0; c < CYC; c++) begin
            checks++;
            if (obs_ov[1][c] !== (c == 10) || obs_on[1][c] !== ((c == 10) ? 8'h22 : 8'h00)) begin
                failures++; $display("FAIL settle_out c=%0d ov=%0b on=%0h", c, obs_ov[1][c], obs_on[1][c]);
            end
        end
        for (int c = 9; c <= 10; c++) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (obs_w[1][c][k] !== stim_w[k] || obs_vgs[1][c][k] !== stim_vgs[k]
                    || obs_vds[1][c][k] !== stim_vds[k]) begin
                    failures++; $display("FAIL settle_ignore c=%0d k=%0d w=%0d exp=%0d", c, k, obs_w[1][c][k], stim_w[k]);
                end
            end
            checks++;
            if (obs_mode[1][c] !== stim_mode) begin
                failures++; $display("FAIL settle_mode c=%0d got=%0d exp=%0d", c, obs_mode[1][c], stim_mode);
            end
        end
        commit_prev();
    endtask

    task automatic test_reset_mid_settle();
        n_beats = 6;
        randomize_stim();
        rst_at = 6;
        run_txn();
        rst_at = -1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 6; c < CYC; c++) begin
                checks++;
                if (obs_ov[d][c] !== 1'b0 || obs_on[d][c] !== 8'h00) begin
                    failures++; $display("FAIL rstmid_out d=%0d c=%0d ov=%0b on=%0h", d, c, obs_ov[d][c], obs_on[d][c]);
                end
                if (c >= 7) begin
                    checks++;
                    if (ports_or(d, c) !== 1'b0 || obs_busy[d][c] !== 1'b0) begin
                        failures++; $display("FAIL rstmid_zero d=%0d c=%0d busy=%0b", d, c, obs_busy[d][c]);
                    end
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            prev_w[k] = 3'd0; prev_vgs[k] = 3'd0; prev_vds[k] = 3'd0;
        end
        prev_mode = 2'd0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            n_beats = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 6;
            randomize_stim();
            run_txn();
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CYC; c++) begin
                    for (int k = 0; k < 6; k++) begin
                        checks++;
                        if (obs_w[d][c][k] !== exp_op(d, c, k, stim_w[k], prev_w[k])
                            || obs_vgs[d][c][k] !== exp_op(d, c, k, stim_vgs[k], prev_vgs[k])
                            || obs_vds[d][c][k] !== exp_op(d, c, k, stim_vds[k], prev_vds[k])) begin
                            failures++;
                            $display("FAIL rnd_ops t=%0d d=%0d c=%0d k=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                     t, d, c, k, obs_w[d][c][k], obs_vgs[d][c][k], obs_vds[d][c][k],
                                     exp_op(d, c, k, stim_w[k], prev_w[k]),
                                     exp_op(d, c, k, stim_vgs[k], prev_vgs[k]),
                                     exp_op(d, c, k, stim_vds[k], prev_vds[k]));
                        end
                    end
                    checks++;
                    if ({1'b0, obs_mode[d][c]} !== exp_op(d, c, 0, {1'b0, stim_mode}, {1'b0, prev_mode})) begin
                        failures++; $display("FAIL rnd_mode t=%0d d=%0d c=%0d got=%0d", t, d, c, obs_mode[d][c]);
                    end
                    checks++;
                    if (obs_ov[d][c] !== exp_ov(d, c) || obs_on[d][c] !== exp_on(d, c)) begin
                        failures++;
                        $display("FAIL rnd_out t=%0d d=%0d c=%0d ov=%0b on=%0h exp_ov=%0b exp_on=%0h",
                                 t, d, c, obs_ov[d][c], obs_on[d][c], exp_ov(d, c), exp_on(d, c));
                    end
                    if (busy_known(c)) begin
                        checks++;
                        if (obs_busy[d][c] !== exp_busy(d, c)) begin
                            failures++;
                            $display("FAIL rnd_busy t=%0d d=%0d c=%0d got=%0b exp=%0b", t, d, c, obs_busy[d][c], exp_busy(d, c));
                        end
                    end
                end
            end
            commit_prev();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; iv1 = 1'b0; iv4 = 1'b0;
        in_w = '0; in_vgs = '0; in_vds = '0; in_mode = '0;
        smc1 = '0; smc4 = '0;
        n_beats = 0; rst_at = -1; pulse4_at = -1;
        test_reset();
        test_full();
        test_abort();
        test_settle_window();
        test_reset_mid_settle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
